// File: rtl/fetch_queue.sv
// fetch_queue
//
// Instruction-fetch stage. Generates sequential word-aligned fetch PCs for a
// synchronous instruction memory with a fixed one-cycle read latency, buffers
// the returned words with their PCs in a small in-order queue, and presents
// the head entry to the ID stage.
//
// Handshakes:
//   - Memory side: a read is requested in any cycle with ImemReq=1.
//     ImemData for that read is valid in the following cycle. There is no
//     ready signal, so the memory must always accept a request.
//   - ID side: ValidD=1 offers {InstrD, PCD}. The entry is consumed at the
//     clock edge when ValidD=1 and StallD=0. When ValidD=0, InstrD shows a
//     NOP and PCD shows 0.
//   - RedirectE=1 discards the queue and any in-flight read, then restarts
//     fetching at the aligned RedirectPC.
//
// Ports:
//   CPU_CLK     in   clock, rising edge
//   CPU_RSTn    in   synchronous active-low reset
//   ImemReq     out  read request this cycle
//   ImemAddr    out  fetch address (bits [1:0] always 00)
//   ImemData    in   read data, one cycle after the request
//   RedirectE   in   control-flow redirect
//   RedirectPC  in   redirect target (bits [1:0] ignored)
//   StallD      in   ID cannot accept this cycle
//   ValidD      out  InstrD/PCD hold a real instruction
//   InstrD      out  head instruction, or NOP (32'h13) when not valid
//   PCD         out  PC of InstrD, or 0 when not valid

module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RSTn,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic [31:0] ImemData,
  input  logic        RedirectE,
  input  logic [31:0] RedirectPC,
  input  logic        StallD,
  output logic        ValidD,
  output logic [31:0] InstrD,
  output logic [31:0] PCD
);

  localparam int          PW         = $clog2(DEPTH);
  localparam int          CW         = PW + 1;
  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          pend_q, pend_d;
  logic [31:0]   pend_pc_q, pend_pc_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   pc_mem_q    [DEPTH];

  logic          valid;
  logic          deq;
  logic          enq;
  logic          issue;
  logic [CW:0]   credit;

  always_comb begin
    // A redirect cycle never presents or consumes an entry.
    valid  = (count_q != '0) & ~RedirectE;
    deq    = valid & ~StallD;
    enq    = pend_q & ~RedirectE;

    // Entries buffered plus the one in flight, minus the one leaving now.
    // Issuing only while this is below DEPTH means every response has a
    // free slot when it arrives. Reset gates the request so that nothing
    // is issued while reset is held.
    credit = {1'b0, count_q} + (CW+1)'(pend_q) - (CW+1)'(deq);
    issue  = CPU_RSTn & ~RedirectE & (credit < (CW+1)'(DEPTH));

    fetch_pc_d = fetch_pc_q;
    pend_d     = 1'b0;
    pend_pc_d  = pend_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;

    if (RedirectE) begin
      fetch_pc_d = RedirectPC & ALIGN_MASK;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      head_d  = head_q + PW'(deq);
      tail_d  = tail_q + PW'(enq);
      count_d = count_q + CW'(enq) - CW'(deq);
      if (issue) begin
        pend_d     = 1'b1;
        pend_pc_d  = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge CPU_CLK) begin
    if (!CPU_RSTn) begin
      fetch_pc_q <= RESET_PC & ALIGN_MASK;
      pend_q     <= 1'b0;
      pend_pc_q  <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Queue storage needs no reset: an entry is only read once count covers it.
  always_ff @(posedge CPU_CLK) begin
    if (CPU_RSTn && enq) begin
      instr_mem_q[tail_q] <= ImemData;
      pc_mem_q[tail_q]    <= pend_pc_q;
    end
  end

  assign ImemReq  = issue;
  assign ImemAddr = fetch_pc_q;
  assign ValidD   = valid;
  assign InstrD   = valid ? instr_mem_q[head_q] : NOP;
  assign PCD      = valid ? pc_mem_q[head_q] : '0;

  // A response landing on a full queue would overwrite the head entry.
  overflow_a: assert property (@(posedge CPU_CLK) disable iff (!CPU_RSTn)
    !(enq && (count_q == CW'(DEPTH))));

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
//
// Bench for fetch_queue (DEPTH=4, RESET_PC=0).
//
// Timing: inputs are driven just after the falling edge, and outputs are
// compared 2 ns later, well before the next rising edge. The memory model
// returns mem_f(addr) one cycle after a request, and returns random noise
// when no request was made.
//
// Reference model: the ID-visible stream is kept as a queue of PCs that have
// returned from memory (exp_q). One flag and one PC describe the in-flight
// read, and one address describes the next fetch.

module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        CPU_CLK    = 1'b0;
  logic        CPU_RSTn   = 1'b0;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic [31:0] ImemData   = '0;
  logic        RedirectE  = 1'b0;
  logic [31:0] RedirectPC = '0;
  logic        StallD     = 1'b0;
  logic        ValidD;
  logic [31:0] InstrD;
  logic [31:0] PCD;

  int total = 0;
  int bad   = 0;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .CPU_CLK   (CPU_CLK),
    .CPU_RSTn  (CPU_RSTn),
    .ImemReq   (ImemReq),
    .ImemAddr  (ImemAddr),
    .ImemData  (ImemData),
    .RedirectE (RedirectE),
    .RedirectPC(RedirectPC),
    .StallD    (StallD),
    .ValidD    (ValidD),
    .InstrD    (InstrD),
    .PCD       (PCD)
  );

  // ---------------- clock / reset ----------------
  always #5 CPU_CLK = ~CPU_CLK;

  // ---------------- instruction memory model ----------------
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h0019_660D) ^ 32'h5A5A_0013;
  endfunction

  always @(posedge CPU_CLK) begin
    if (ImemReq) ImemData <= mem_f(ImemAddr);
    else         ImemData <= $urandom();
  end

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] exp_q[$];
  bit          m_pend;
  logic [31:0] m_pend_pc;
  logic [31:0] m_fetch;

  task automatic model_reset();
    exp_q.delete();
    m_pend    = 1'b0;
    m_pend_pc = '0;
    m_fetch   = RESET_PC;
  endtask

  // Compares the DUT's outputs for the current cycle, then advances the
  // model to the state it should have after the next rising edge.
  task automatic model_cycle();
    bit          e_valid;
    bit          e_deq;
    bit          e_req;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    e_valid = (exp_q.size() != 0) && !RedirectE;
    e_pc    = e_valid ? exp_q[0] : 32'h0;
    e_instr = e_valid ? mem_f(exp_q[0]) : NOP;
    e_deq   = e_valid && !StallD;
    e_req   = CPU_RSTn && !RedirectE &&
              (exp_q.size() + int'(m_pend) - int'(e_deq) < DEPTH);

    chk("model_valid", 32'(ValidD),  32'(e_valid));
    chk("model_pcd",   PCD,          e_pc);
    chk("model_instr", InstrD,       e_instr);
    chk("model_req",   32'(ImemReq), 32'(e_req));
    chk("model_addr",  ImemAddr,     m_fetch);

    if (!CPU_RSTn) begin
      model_reset();
    end else if (RedirectE) begin
      exp_q.delete();
      m_pend  = 1'b0;
      m_fetch = RedirectPC & 32'hFFFF_FFFC;
    end else begin
      if (e_deq) void'(exp_q.pop_front());
      if (m_pend) exp_q.push_back(m_pend_pc);
      if (e_req) begin
        m_pend    = 1'b1;
        m_pend_pc = m_fetch;
        m_fetch   = m_fetch + 32'd4;
      end else begin
        m_pend = 1'b0;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit rst_n, input bit stall, input bit redir,
                      input logic [31:0] rpc);
    @(negedge CPU_CLK);
    CPU_RSTn   = rst_n;
    StallD     = stall;
    RedirectE  = redir;
    RedirectPC = rpc;
    #2;
    model_cycle();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          rst_n;
    bit          stall;
    bit          redir;
    logic [31:0] rpc;
    bit          e_valid;
    logic [31:0] e_pc;
    bit          e_req;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vt[$];

  task automatic add(input bit rst_n, input bit stall, input bit redir,
                     input logic [31:0] rpc, input bit ev, input logic [31:0] epc,
                     input bit ereq, input logic [31:0] eaddr);
    vec_t v;
    v.rst_n = rst_n; v.stall = stall; v.redir = redir; v.rpc = rpc;
    v.e_valid = ev; v.e_pc = epc; v.e_req = ereq; v.e_addr = eaddr;
    vt.push_back(v);
  endtask

  initial begin
    logic [31:0] got [3];
    logic [31:0] wrap_exp [3];
    int          n;
    logic [31:0] rpc;
    bit          r_rst;
    bit          r_redir;
    bit          r_stall;

    // reset held for two edges
    CPU_RSTn = 1'b0;
    repeat (2) @(posedge CPU_CLK);
    model_reset();

    //   rst stall redir rpc          valid pc           req addr
    // reset values, startup and streaming
    add(0, 0, 0, 32'h0,         0, 32'h0,          0, 32'h0);
    add(1, 0, 0, 32'h0,         0, 32'h0,          1, 32'h0);
    add(1, 0, 0, 32'h0,         0, 32'h0,          1, 32'h4);
    add(1, 0, 0, 32'h0,         1, 32'h0,          1, 32'h8);
    add(1, 0, 0, 32'h0,         1, 32'h4,          1, 32'hC);
    // stall from the third valid instruction for 10 cycles
    add(1, 1, 0, 32'h0,         1, 32'h8,          1, 32'h10);
    add(1, 1, 0, 32'h0,         1, 32'h8,          1, 32'h14);
    for (int i = 0; i < 8; i++)
      add(1, 1, 0, 32'h0,       1, 32'h8,          0, 32'h18);
    // release: 8,12,16,20,24 back-to-back, requests resume at once
    add(1, 0, 0, 32'h0,         1, 32'h8,          1, 32'h18);
    add(1, 0, 0, 32'h0,         1, 32'hC,          1, 32'h1C);
    add(1, 0, 0, 32'h0,         1, 32'h10,         1, 32'h20);
    add(1, 0, 0, 32'h0,         1, 32'h14,         1, 32'h24);
    add(1, 0, 0, 32'h0,         1, 32'h18,         1, 32'h28);
    // redirect to 0x103 with reads in flight
    add(1, 0, 1, 32'h103,       0, 32'h0,          0, 32'h2C);
    add(1, 0, 0, 32'h0,         0, 32'h0,          1, 32'h100);
    add(1, 0, 0, 32'h0,         0, 32'h0,          1, 32'h104);
    add(1, 0, 0, 32'h0,         1, 32'h100,        1, 32'h108);
    add(1, 0, 0, 32'h0,         1, 32'h104,        1, 32'h10C);
    // fill the queue, then redirect with StallD=0 against a full queue
    add(1, 1, 0, 32'h0,         1, 32'h108,        1, 32'h110);
    add(1, 1, 0, 32'h0,         1, 32'h108,        1, 32'h114);
    add(1, 1, 0, 32'h0,         1, 32'h108,        0, 32'h118);
    add(1, 1, 0, 32'h0,         1, 32'h108,        0, 32'h118);
    add(1, 0, 1, 32'h200,       0, 32'h0,          0, 32'h118);
    add(1, 0, 0, 32'h0,         0, 32'h0,          1, 32'h200);
    add(1, 0, 0, 32'h0,         0, 32'h0,          1, 32'h204);
    // half-full queue, one-cycle reset, restart at RESET_PC
    add(1, 1, 0, 32'h0,         1, 32'h200,        1, 32'h208);
    add(0, 1, 0, 32'h0,         1, 32'h200,        0, 32'h20C);
    add(1, 0, 0, 32'h0,         0, 32'h0,          1, 32'h0);
    add(1, 0, 0, 32'h0,         0, 32'h0,          1, 32'h4);
    add(1, 0, 0, 32'h0,         1, 32'h0,          1, 32'h8);

    foreach (vt[i]) begin
      step(vt[i].rst_n, vt[i].stall, vt[i].redir, vt[i].rpc);
      chk($sformatf("tab%0d_valid", i), 32'(ValidD),  32'(vt[i].e_valid));
      chk($sformatf("tab%0d_pcd", i),   PCD,          vt[i].e_pc);
      chk($sformatf("tab%0d_instr", i), InstrD,
          vt[i].e_valid ? mem_f(vt[i].e_pc) : NOP);
      chk($sformatf("tab%0d_req", i),   32'(ImemReq), 32'(vt[i].e_req));
      chk($sformatf("tab%0d_addr", i),  ImemAddr,     vt[i].e_addr);
    end

    // hand sequence: PC wrap at the top of the address space
    wrap_exp[0] = 32'hFFFF_FFF8;
    wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0000_0000;
    foreach (got[i]) got[i] = 32'hDEAD_BEEF;
    step(1, 0, 1, 32'hFFFF_FFF8);
    n = 0;
    for (int c = 0; c < 12 && n < 3; c++) begin
      step(1, 0, 0, 32'h0);
      if (ValidD) begin
        got[n] = PCD;
        n++;
      end
    end
    chk("wrap_count", 32'(n), 32'd3);
    foreach (got[i]) chk($sformatf("wrap_pc%0d", i), got[i], wrap_exp[i]);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      r_rst   = ($urandom_range(0, 199) != 0);
      r_redir = ($urandom_range(0, 99) < 4);
      r_stall = ($urandom_range(0, 99) < 35);
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
      else                           rpc = $urandom();
      step(r_rst, r_stall, r_redir, rpc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction-fetch stage of the RISC-V pipeline. It generates sequential fetch PCs and drives the synchronous instruction memory, which has a fixed 1-cycle read latency. Returned words are buffered with their PCs in a small in-order queue, and the head entry is presented to the ID stage, where the instruction decoder slices Op/Fn3/Fn7 from InstrD. Back-pressure comes from an ID stall. Redirects from branch/JAL/JALR resolution flush the queue and any in-flight read.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- CPU_CLK  in  1  sole clock; all state updates on its rising edge.
- CPU_RSTn  in  1  reset; synchronous, active-low.
- ImemReq  out  1  read request to instruction memory this cycle.
- ImemAddr  out  32  word-aligned fetch address; bits [1:0] always 00.
- ImemData  in  32  read data; valid exactly one cycle after the cycle in which ImemReq was high.
- RedirectE  in  1  control-flow redirect from the resolving stage.
- RedirectPC  in  32  redirect target; bits [1:0] ignored (treated as 00).
- StallD  in  1  ID stage cannot accept an instruction this cycle.
- ValidD  out  1  InstrD/PCD hold a real instruction.
- InstrD  out  32  head instruction; 32'h0000_0013 (addi x0,x0,0) whenever ValidD=0.
- PCD  out  32  PC of InstrD; 0 whenever ValidD=0.

## Operation
State:
- FetchPC: next address to request.
- Pending flag and PendPC: a read is in flight, and its address.
- Circular queue of {instr, pc} with head pointer, tail pointer and count (0..DEPTH).

Dequeue, Deq = ValidD & ~StallD & ~RedirectE:
- Head advances and count decrements.
- ValidD = (count != 0). InstrD/PCD read combinationally from the head entry.

Issue:
- ImemReq = ~RedirectE & (count + Pending - Deq < DEPTH).
- When issuing: ImemAddr = FetchPC, Pending <= 1, PendPC <= FetchPC, FetchPC <= FetchPC + 4 (wraps modulo 2^32).
- When not issuing: Pending <= 0, FetchPC holds, ImemAddr = FetchPC.

Capture:
- If Pending = 1 and no redirect this cycle: {ImemData, PendPC} is written at tail, tail advances, count increments.
- Enqueue and dequeue in the same cycle leave count unchanged.
- The credit rule guarantees an enqueue never meets a full queue. Overflow is a design error and an assertion must fire on it.

Redirect (RedirectE = 1):
- Clear the queue (count, head and tail to 0) and set Pending <= 0. A response arriving this cycle or already in flight is discarded.
- FetchPC <= {RedirectPC[31:2], 2'b00}. ImemReq = 0 this cycle.
- ValidD is forced to 0 in the redirect cycle, and InstrD shows the NOP.

Priority: reset > redirect > capture/dequeue/issue.

## Timing
Reset values (reset asserted at an edge):
- FetchPC = RESET_PC, Pending = 0, count/head/tail = 0.
- Outputs: ImemReq = 0, ImemAddr = RESET_PC, ValidD = 0, InstrD = 32'h13, PCD = 0.

Startup:
- Reset deasserted before edge N; cycle N has ImemReq = 1, ImemAddr = RESET_PC.
- Data arrives in N+1 and is captured at the end of N+1.
- ValidD = 1 in N+2 with PCD = RESET_PC.

Redirect latency:
- RedirectE in cycle R.
- R+1: ImemReq = 1, ImemAddr = target.
- R+3: ValidD = 1 with PCD = target.

Throughput and stall behaviour:
- Steady state with StallD = 0: one instruction per cycle, PCD incrementing by 4.
- Under sustained StallD, the queue fills to DEPTH and ImemReq drops. With DEPTH = 4, at most 4 requests are outstanding plus buffered.
- Stall release: ValidD stays continuously 1 and requests resume in the same cycle as the first dequeue.

Reset mid-operation: the queue, the in-flight read and any redirect are abandoned, with values as above at the next edge.

## Test plan
- Reset then run with StallD = 0 -> ImemAddr 0,4,8,… from the first post-reset cycle; ValidD rises 2 cycles later; PCD 0,4,8,… back-to-back; InstrD equals the memory model contents.
- Hold StallD = 1 from the 3rd valid instruction for 10 cycles -> count saturates at 4 and ImemReq = 0. InstrD/PCD stay frozen at PC 8. On release, PCs 8,12,16,20,24 are delivered with no gaps or duplicates.
- RedirectE with RedirectPC = 32'h0000_0103 while a read is in flight -> the in-flight word is never presented. ImemAddr = 0x100 one cycle later and PCD = 0x100 three cycles after the redirect.
- RedirectE asserted with StallD = 0 and a full queue in the same cycle -> ValidD = 0 that cycle and no stale PC appears afterward.
- FetchPC = 32'hFFFF_FFFC streaming -> the next request is address 0 (wrap).
- CPU_RSTn low for 1 cycle mid-stream with the queue half full -> the next cycle shows reset values, followed by a restart at RESET_PC per startup timing.
